// File: rtl/sram_axi_bridge_mc_if.sv
// sram_axi_bridge_mc_if
//   Bundles the sram-like requestor side and the single-beat AXI3 master
//   side of the multi-channel bridge.
//   Modports:
//     master - the bridge: takes ch_* requests, drives addr_ok/data_ok/rdata,
//              and acts as the AXI master (AR/AW/W valids, R/B readies).
//     slave  - the environment: the requestors plus the AXI slave.
//   Per-channel packing: ch_size ch i at [2i+1:2i], ch_addr/ch_wdata ch i at
//   [32i+31:32i].
interface sram_axi_bridge_mc_if #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 4
);
  // sram-like requestors
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_wr;
  logic [2*NUM_CH-1:0]  ch_size;
  logic [32*NUM_CH-1:0] ch_addr;
  logic [32*NUM_CH-1:0] ch_wdata;
  logic [NUM_CH-1:0]    ch_addr_ok;
  logic [NUM_CH-1:0]    ch_data_ok;
  logic [31:0]          ch_rdata;
  // AXI read address / data
  logic [ID_W-1:0]      arid;
  logic [31:0]          araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic [1:0]           arlock;
  logic [3:0]           arcache;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [ID_W-1:0]      rid;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;
  // AXI write address / data / response
  logic [ID_W-1:0]      awid;
  logic [31:0]          awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic [1:0]           awlock;
  logic [3:0]           awcache;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [ID_W-1:0]      wid;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;
  logic [ID_W-1:0]      bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge_mc.sv
// sram_axi_bridge_mc
//   Multi-channel sram-like to AXI3 bridge. NUM_CH requestors are arbitrated
//   by independent read and write round-robin arbiters; one single-beat read
//   and one single-beat write may be outstanding at the same time. A read
//   whose word address matches an in-flight or same-cycle-granted write is
//   held back until the write completes.
//   Ports:
//     clk   - clock, all logic on posedge
//     reset - synchronous active-high reset
//     bus   - sram_axi_bridge_mc_if.master (requestor side + AXI master side)
module sram_axi_bridge_mc #(
  parameter int NUM_CH = 2,
  parameter int ID_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_axi_bridge_mc_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_e;

  function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    wstrb_f = 4'b0001 << lo;
      2'd1:    wstrb_f = lo[1] ? 4'b1100 : 4'b0011;
      default: wstrb_f = 4'b1111;
    endcase
  endfunction

  // Returns {found, index}: first eligible channel at or above ptr, else the
  // lowest eligible channel (wrap-around of the round-robin search).
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                            input logic [CH_W-1:0]   ptr);
    logic            hi_f;
    logic            lo_f;
    logic [CH_W-1:0] hi_s;
    logic [CH_W-1:0] lo_s;
    hi_f = 1'b0;
    lo_f = 1'b0;
    hi_s = '0;
    lo_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hi_f && elig[i] && (i >= int'(ptr))) begin
        hi_f = 1'b1;
        hi_s = CH_W'(i);
      end
      if (!lo_f && elig[i]) begin
        lo_f = 1'b1;
        lo_s = CH_W'(i);
      end
    end
    rr_pick = hi_f ? {1'b1, hi_s} : {lo_f, lo_s};
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] g);
    rr_next = (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
  endfunction

  // state
  r_state_e        r_state_q, r_state_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [1:0]      r_size_q, r_size_d;
  logic [CH_W-1:0] r_id_q, r_id_d;
  logic [CH_W-1:0] rd_ptr_q, rd_ptr_d;

  w_state_e        w_state_q, w_state_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [1:0]      w_size_q, w_size_d;
  logic [31:0]     w_data_q, w_data_d;
  logic [CH_W-1:0] w_id_q, w_id_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [CH_W-1:0] wr_ptr_q, wr_ptr_d;

  // a set bit means the channel has an accepted, not yet completed request
  logic [NUM_CH-1:0] busy_q, busy_d;

  // arbitration
  logic [NUM_CH-1:0] wr_elig, rd_elig, haz;
  logic [NUM_CH-1:0] wr_gnt, rd_gnt, wr_dok, rd_dok;
  logic              wr_found, rd_found;
  logic [CH_W-1:0]   wr_sel, rd_sel;
  logic [31:0]       wr_gaddr, wr_gdata, rd_gaddr;
  logic [1:0]        wr_gsize, rd_gsize;

  always_comb begin
    wr_elig  = '0;
    rd_elig  = '0;
    haz      = '0;
    wr_gnt   = '0;
    rd_gnt   = '0;
    wr_gaddr = '0;
    wr_gdata = '0;
    wr_gsize = '0;
    rd_gaddr = '0;
    rd_gsize = '0;

    // Write side first: the read hazard check needs the same-cycle write grant.
    for (int i = 0; i < NUM_CH; i++)
      wr_elig[i] = bus.ch_req[i] & bus.ch_wr[i] & ~busy_q[i] & (w_state_q == W_IDLE);
    {wr_found, wr_sel} = rr_pick(wr_elig, wr_ptr_q);
    for (int i = 0; i < NUM_CH; i++) begin
      wr_gnt[i] = wr_found && (int'(wr_sel) == i);
      if (wr_gnt[i]) begin
        wr_gaddr = bus.ch_addr[32*i +: 32];
        wr_gdata = bus.ch_wdata[32*i +: 32];
        wr_gsize = bus.ch_size[2*i +: 2];
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      haz[i] = ((w_state_q != W_IDLE) && (bus.ch_addr[32*i+2 +: 30] == w_addr_q[31:2])) ||
               (wr_found && (bus.ch_addr[32*i+2 +: 30] == wr_gaddr[31:2]));
      rd_elig[i] = bus.ch_req[i] & ~bus.ch_wr[i] & ~busy_q[i] & (r_state_q == R_IDLE) & ~haz[i];
    end
    {rd_found, rd_sel} = rr_pick(rd_elig, rd_ptr_q);
    for (int i = 0; i < NUM_CH; i++) begin
      rd_gnt[i] = rd_found && (int'(rd_sel) == i);
      if (rd_gnt[i]) begin
        rd_gaddr = bus.ch_addr[32*i +: 32];
        rd_gsize = bus.ch_size[2*i +: 2];
      end
    end
  end

  // completions are routed by the latched channel index, not by rid/bid
  always_comb begin
    rd_dok = '0;
    wr_dok = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_dok[i] = (r_state_q == R_R) && bus.rvalid && (int'(r_id_q) == i);
      wr_dok[i] = (w_state_q == W_B) && bus.bvalid && (int'(w_id_q) == i);
    end
  end

  // read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_size_d  = r_size_q;
    r_id_d    = r_id_q;
    rd_ptr_d  = rd_ptr_q;
    case (r_state_q)
      R_IDLE: if (rd_found) begin
        r_state_d = R_AR;
        r_addr_d  = rd_gaddr;
        r_size_d  = rd_gsize;
        r_id_d    = rd_sel;
        rd_ptr_d  = rr_next(rd_sel);
      end
      R_AR:    if (bus.arready) r_state_d = R_R;
      R_R:     if (bus.rvalid)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // write FSM next state; AW and W handshakes are tracked separately
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_size_d  = w_size_q;
    w_data_d  = w_data_q;
    w_id_d    = w_id_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_ptr_d  = wr_ptr_q;
    case (w_state_q)
      W_IDLE: if (wr_found) begin
        w_state_d = W_REQ;
        w_addr_d  = wr_gaddr;
        w_size_d  = wr_gsize;
        w_data_d  = wr_gdata;
        w_id_d    = wr_sel;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        wr_ptr_d  = rr_next(wr_sel);
      end
      W_REQ: begin
        if ((aw_done_q || bus.awready) && (w_done_q || bus.wready)) begin
          w_state_d = W_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | bus.awready;
          w_done_d  = w_done_q | bus.wready;
        end
      end
      W_B:     if (bus.bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign busy_d = (busy_q | rd_gnt | wr_gnt) & ~(rd_dok | wr_dok);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_id_q    <= '0;
      rd_ptr_q  <= '0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_data_q  <= '0;
      w_id_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_ptr_q  <= '0;
      busy_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_size_q  <= r_size_d;
      r_id_q    <= r_id_d;
      rd_ptr_q  <= rd_ptr_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_size_q  <= w_size_d;
      w_data_q  <= w_data_d;
      w_id_q    <= w_id_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_ptr_q  <= wr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // requestor side
  assign bus.ch_addr_ok = rd_gnt | wr_gnt;
  assign bus.ch_data_ok = rd_dok | wr_dok;
  assign bus.ch_rdata   = bus.rdata;

  // AXI read
  assign bus.arid    = ID_W'(r_id_q);
  assign bus.araddr  = r_addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, r_size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = (r_state_q == R_AR);
  assign bus.rready  = (r_state_q == R_R);

  // AXI write
  assign bus.awid    = ID_W'(w_id_q);
  assign bus.awaddr  = w_addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, w_size_q};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;
  assign bus.awvalid = (w_state_q == W_REQ) && !aw_done_q;
  assign bus.wid     = ID_W'(w_id_q);
  assign bus.wdata   = w_data_q;
  assign bus.wstrb   = wstrb_f(w_size_q, w_addr_q[1:0]);
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = (w_state_q == W_REQ) && !w_done_q;
  assign bus.bready  = (w_state_q == W_B);

  // response IDs and status are not used for routing or error reporting
  logic unused_axi;
  assign unused_axi = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};
endmodule

// File: tb/tb_sram_axi_bridge_mc.sv
// tb_sram_axi_bridge_mc
//   Self-checking bench for sram_axi_bridge_mc (NUM_CH=2, ID_W=4). A vector
//   table drives single transactions; hand-written sequences cover delayed
//   handshakes, round-robin, the read-after-write hazard, reset mid-read and
//   simultaneous completions. Completions are checked against a scoreboard
//   queue filled when requests are accepted.
module tb_sram_axi_bridge_mc;
  logic clk;
  logic reset;

  sram_axi_bridge_mc_if #(.NUM_CH(2), .ID_W(4)) bus ();

  sram_axi_bridge_mc #(.NUM_CH(2), .ID_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    int          ch;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   pos;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int ch, input bit wr, input logic [31:0] rdata);
    sb_t e;
    e.ch = ch;
    e.wr = wr;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_req   = '0;
    bus.ch_wr    = '0;
    bus.ch_size  = '0;
    bus.ch_addr  = '0;
    bus.ch_wdata = '0;
    bus.arready  = 1'b0;
    bus.rid      = '0;
    bus.rdata    = '0;
    bus.rresp    = '0;
    bus.rlast    = 1'b1;
    bus.rvalid   = 1'b0;
    bus.awready  = 1'b0;
    bus.wready   = 1'b0;
    bus.bid      = '0;
    bus.bresp    = '0;
    bus.bvalid   = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb_q.delete();
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // waits (bounded) for any addr_ok; returns at the negedge where it is seen
  task automatic wait_grant(output logic [1:0] got);
    got = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ch_addr_ok != 2'b00) begin
        got = bus.ch_addr_ok;
        break;
      end
      step();
    end
    if (got == 2'b00) chk("addr_ok_timeout", 0, 1);
  endtask

  // completion monitor: every data_ok bit must match a pending transaction
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (bus.ch_data_ok[c] === 1'b1) begin
        pos = -1;
        foreach (sb_q[j]) if (pos < 0 && sb_q[j].ch == c) pos = j;
        total++;
        if (pos < 0) begin
          bad++;
          $display("FAIL sb_unexpected ch=%0d actual data_ok=1 expected no pending txn (t=%0t)", c, $time);
        end else begin
          if (!sb_q[pos].wr) chk("sb_rdata", bus.ch_rdata, sb_q[pos].rdata);
          sb_q.delete(pos);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.ch;
    bus.ch_req   = oh;
    bus.ch_wr    = v.wr ? oh : 2'b00;
    bus.ch_size  = 4'(v.size) << (2 * v.ch);
    bus.ch_addr  = 64'(v.addr) << (32 * v.ch);
    bus.ch_wdata = 64'(v.wdata) << (32 * v.ch);
    @(negedge clk);
    chk("vec_addr_ok", bus.ch_addr_ok, oh);
    sb_push(v.ch, v.wr, v.rdata);
    step();
    bus.ch_req = '0;
    if (!v.wr) begin
      bus.arready = 1'b1;
      @(negedge clk);
      chk("vec_arvalid", bus.arvalid, 1);
      chk("vec_araddr", bus.araddr, v.addr);
      chk("vec_arsize", bus.arsize, {1'b0, v.size});
      chk("vec_arid", bus.arid, v.ch);
      chk("vec_arlen_burst", {bus.arlen, bus.arburst}, 10'b00000000_01);
      step();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = v.rdata;
      bus.rid     = 4'(v.ch);
      @(negedge clk);
      chk("vec_rready", {bus.arvalid, bus.rready}, 2'b01);
      step();
      bus.rvalid = 1'b0;
    end else begin
      bus.awready = 1'b1;
      bus.wready  = 1'b1;
      @(negedge clk);
      chk("vec_aw_w_valid", {bus.awvalid, bus.wvalid, bus.wlast}, 3'b111);
      chk("vec_awaddr", bus.awaddr, v.addr);
      chk("vec_awsize", bus.awsize, {1'b0, v.size});
      chk("vec_awid_wid", {bus.awid, bus.wid}, {4'(v.ch), 4'(v.ch)});
      chk("vec_wstrb", bus.wstrb, v.strb);
      chk("vec_wdata", bus.wdata, v.wdata);
      step();
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b1;
      @(negedge clk);
      chk("vec_bready", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
      step();
      bus.bvalid = 1'b0;
    end
    @(negedge clk);
    chk("vec_sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] got;
    logic [1:0] exp_oh;

    vecs[0] = '{0, 0, 32'hBFC00000, 2'd2, 32'h00000000, 4'h0,    32'h3C1D0001};
    vecs[1] = '{1, 1, 32'h80000003, 2'd0, 32'hAA000000, 4'b1000, 32'h0};
    vecs[2] = '{1, 0, 32'h80000002, 2'd1, 32'h12340000, 4'b1100, 32'h0};
    vecs[3] = '{1, 1, 32'h80000000, 2'd1, 32'h00005678, 4'b0011, 32'h0};
    vecs[4] = '{1, 0, 32'h80000001, 2'd0, 32'h0000BB00, 4'b0010, 32'h0};
    vecs[5] = '{1, 1, 32'h80000010, 2'd2, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[6] = '{0, 1, 32'h80000020, 2'd0, 32'h00000000, 4'h0,    32'h55AA55AA};
    vecs[7] = '{1, 0, 32'h80000004, 2'd3, 32'hCAFEF00D, 4'b1111, 32'h0};

    // reset state
    reset = 1'b1;
    clear_inputs();
    step();
    @(negedge clk);
    chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);
    chk("rst_oks", {bus.ch_addr_ok, bus.ch_data_ok}, 4'b0);
    chk("rst_latched", {bus.araddr, bus.awaddr}, 64'h0);
    chk("rst_ids_wdata", {bus.arid, bus.awid, bus.wdata}, 40'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);
    step();

    // single transactions from the table
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // delayed awready, immediate wready
    bus.ch_req = 2'b10; bus.ch_wr = 2'b10; bus.ch_size = 4'b0000;
    bus.ch_addr = {32'h80000003, 32'h0}; bus.ch_wdata = {32'hAA000000, 32'h0};
    @(negedge clk);
    chk("dly_addr_ok", bus.ch_addr_ok, 2'b10);
    sb_push(1, 1, 32'h0);
    step();
    bus.ch_req = '0; bus.wready = 1'b1;
    @(negedge clk);
    chk("dly_t1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
    chk("dly_t1_strb", bus.wstrb, 4'b1000);
    step();
    bus.wready = 1'b0;
    @(negedge clk);
    chk("dly_t2_valids", {bus.awvalid, bus.wvalid}, 2'b10);
    step();
    @(negedge clk);
    chk("dly_t3_awvalid", {bus.awvalid, bus.bready}, 2'b10);
    step();
    bus.awready = 1'b1;
    @(negedge clk);
    chk("dly_t4_awvalid", {bus.awvalid, bus.awaddr}, {1'b1, 32'h80000003});
    step();
    bus.awready = 1'b0; bus.bvalid = 1'b1;
    @(negedge clk);
    chk("dly_t5_bready", {bus.awvalid, bus.bready}, 2'b01);
    step();
    bus.bvalid = 1'b0;
    @(negedge clk);
    chk("dly_done", {bus.bready, 32'(sb_q.size())}, 33'h0);

    // round-robin between two held read requests
    apply_reset();
    bus.ch_req = 2'b11; bus.ch_wr = 2'b00; bus.ch_size = 4'b1010;
    bus.ch_addr = {32'h80006100, 32'h80006000};
    for (int t = 0; t < 6; t++) begin
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(got);
      chk("rr_grant", got, exp_oh);
      sb_push(t % 2, 0, 32'hC0DE0000 + t);
      step();
      if (t == 5) bus.ch_req = '0;
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hC0DE0000 + t;
      step();
      bus.rvalid = 1'b0;
    end
    @(negedge clk);
    chk("rr_drained", sb_q.size(), 0);
    step();

    // read-after-write hazard
    bus.ch_req = 2'b10; bus.ch_wr = 2'b10; bus.ch_size = 4'b1010;
    bus.ch_addr = {32'h80001004, 32'h0}; bus.ch_wdata = {32'h11223344, 32'h0};
    @(negedge clk);
    chk("haz_w_addr_ok", bus.ch_addr_ok, 2'b10);
    sb_push(1, 1, 32'h0);
    step();
    bus.ch_req = '0; bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.ch_req = 2'b01; bus.ch_wr = 2'b00; bus.ch_addr = {32'h0, 32'h80001006};
    @(negedge clk);
    chk("haz_blocked_a", bus.ch_addr_ok, 2'b00);
    step();
    @(negedge clk);
    chk("haz_blocked_b", bus.ch_addr_ok, 2'b00);
    step();
    bus.ch_addr = {32'h0, 32'h80002000};
    @(negedge clk);
    chk("haz_other_granted", bus.ch_addr_ok, 2'b01);
    sb_push(0, 0, 32'h0BADCAFE);
    step();
    bus.ch_req = '0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0BADCAFE;
    step();
    bus.rvalid = 1'b0;
    bus.ch_req = 2'b01; bus.ch_addr = {32'h0, 32'h80001006};
    @(negedge clk);
    chk("haz_w_still_pending", {bus.bready, bus.ch_addr_ok}, 3'b100);
    step();
    bus.bvalid = 1'b1;
    @(negedge clk);
    chk("haz_blocked_at_bvalid", bus.ch_addr_ok, 2'b00);
    step();
    bus.bvalid = 1'b0;
    @(negedge clk);
    chk("haz_released", bus.ch_addr_ok, 2'b01);
    sb_push(0, 0, 32'h13572468);
    step();
    bus.ch_req = '0; bus.arready = 1'b1;
    @(negedge clk);
    chk("haz_araddr", bus.araddr, 32'h80001006);
    step();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h13572468;
    step();
    bus.rvalid = 1'b0;
    @(negedge clk);
    chk("haz_drained", sb_q.size(), 0);
    step();

    // reset while waiting for rvalid
    bus.ch_req = 2'b01; bus.ch_wr = 2'b00; bus.ch_addr = {32'h0, 32'h80003000};
    @(negedge clk);
    chk("rst_mid_addr_ok", bus.ch_addr_ok, 2'b01);
    sb_push(0, 0, 32'h0);
    step();
    bus.ch_req = '0; bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_rr", bus.rready, 1);
    step();
    reset = 1'b1;
    sb_q.delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_idle", {bus.arvalid, bus.rready, bus.ch_data_ok}, 4'b0);
    step();
    bus.rvalid = 1'b1; bus.rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rst_mid_no_data_ok", {bus.rready, bus.ch_data_ok}, 3'b0);
    step();
    bus.rvalid = 1'b0;
    run_vec('{0, 0, 32'h80003000, 2'd2, 32'h0, 4'h0, 32'h24681357});
    step();

    // simultaneous read and write completion
    bus.ch_req = 2'b11; bus.ch_wr = 2'b10; bus.ch_size = 4'b1010;
    bus.ch_addr = {32'h80005000, 32'h80004000}; bus.ch_wdata = {32'h99887766, 32'h0};
    @(negedge clk);
    chk("sim_addr_ok", bus.ch_addr_ok, 2'b11);
    sb_push(0, 0, 32'h600DF00D);
    sb_push(1, 1, 32'h0);
    step();
    bus.ch_req = '0; bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h600DF00D; bus.bvalid = 1'b1;
    @(negedge clk);
    chk("sim_data_ok", bus.ch_data_ok, 2'b11);
    chk("sim_rdata", bus.ch_rdata, 32'h600DF00D);
    step();
    bus.rvalid = 1'b0; bus.bvalid = 1'b0;
    @(negedge clk);
    chk("sim_drained", {bus.ch_data_ok, 32'(sb_q.size())}, 34'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
